// File: rtl/logicboy_pkg.sv
// logicboy_pkg: shared widths and the block-reader state encoding
package logicboy_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} mbr_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO, power-of-2 depth
// Ports: wr_en/wr_data push, rd_en pops the head shown on rd_data,
//        empty flags no data, count is the current occupancy.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic full, push, pop;

    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    // head reads as zero when empty so a flushed FIFO presents 0x00
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mem_block_reader.sv
// mem_block_reader: reads a contiguous memory range and streams it out
// Ports: start edge launches a read of length bytes from base_addr;
//        bus_req/rd_addr/rd_data drive the memory read port;
//        out_data/out_valid/out_ready form the byte stream;
//        busy marks a transfer, done is sticky until the next launch.
module mem_block_reader
    import logicboy_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        length,
    output logic              bus_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mbr_state_t state_q, state_d;
    logic start_q;
    logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d;
    logic [8:0] cnt_q, cnt_d, issued_q, issued_d;
    logic [READ_LATENCY-1:0] tok_q, tok_d;
    logic [3:0] outst;
    logic [CW-1:0] fifo_count;
    logic fifo_empty, launch, credit, issue;

    assign outst  = 4'($countones(tok_q));
    assign launch = start & ~start_q & (state_q == IDLE | state_q == DONE);
    // credit uses registered occupancy, so a pop in this cycle frees nothing yet
    assign credit = 9'(fifo_count) + 9'(outst) < 9'(FIFO_DEPTH);
    assign issue  = state_q == READ && issued_q != cnt_q && credit;

    assign rd_addr   = issue ? addr_q : last_q;
    assign bus_req   = state_q == READ | (state_q == DRAIN & outst != 4'd0);
    assign busy      = state_q == READ | state_q == DRAIN;
    assign done      = state_q == DONE;
    assign out_valid = ~fifo_empty;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        tok_d    = tok_q << 1;
        tok_d[0] = issue;
        if (launch) begin
            state_d  = READ;
            addr_d   = base_addr;
            cnt_d    = length == 8'd0 ? 9'd256 : {1'b0, length};
            issued_d = '0;
        end
        if (issue) begin
            addr_d   = addr_q + 8'd1;
            last_d   = addr_q;
            issued_d = issued_q + 9'd1;
        end
        if (state_q == READ && issued_q == cnt_q) state_d = DRAIN;
        if (state_q == DRAIN && outst == 4'd0 && fifo_count == '0) state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            addr_q   <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            issued_q <= '0;
            tok_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            addr_q   <= addr_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            tok_q    <= tok_d;
        end
    end

    // the token leaving the latency pipe marks rd_data as this cycle's read return
    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tok_q[READ_LATENCY-1]),
        .wr_data (rd_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_mem_block_reader.sv
// tb_mem_block_reader: scoreboard bench for mem_block_reader
module tb_mem_block_reader;
    logic clk = 1'b0;
    logic reset, start, bus_req, out_valid, busy, done;
    logic out_ready = 1'b1;
    logic [7:0] base_addr, length, rd_addr, rd_data, out_data;
    logic [7:0] key = 8'hA5;
    logic [7:0] q [$];
    logic [7:0] prev_data;
    bit prev_stall = 1'b0;
    logic prev_done = 1'b0;
    int n_chk = 0, n_pass = 0;
    int delivered = 0, done_rises = 0, wr_full = 0;
    int rdy_mode = 0, ph = 0;
    int d0, r0;

    always #5 clk = ~clk;

    mem_block_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus_req   (bus_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) rd_data <= rd_addr ^ key;

    always begin
        @(posedge clk);
        #1;
        out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'b0;
        ph++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("extra_byte", 32'(q.size()), 32'd1);
                else chk("byte", 32'(out_data), 32'(q.pop_front()));
                delivered++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (dut.u_fifo.wr_en && dut.u_fifo.full) wr_full++;
            if (done && !prev_done) done_rises++;
        end
        prev_done = done;
    end

    task automatic go(input logic [7:0] b, input logic [7:0] l);
        logic [7:0] a;
        @(posedge clk);
        #1;
        base_addr = b;
        length = l;
        start = 1'b1;
        for (int i = 0; i < (l == 8'd0 ? 256 : int'(l)); i++) begin
            a = b + 8'(i);
            q.push_back(a ^ key);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done; k++) @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("sb_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        go(8'h10, 8'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("issue_addr", 32'(rd_addr), 32'h10 + 32'(i));
            chk("first_valid", 32'(out_valid), 32'(i >= 2));
        end
        wait_done(50);
        chk("idle_busy", 32'(busy), 32'd0);

        rdy_mode = 1;
        go(8'h10, 8'd4);
        wait_done(100);
        rdy_mode = 2;
        go(8'h20, 8'd12);
        repeat (12) @(negedge clk);
        chk("stall_addr", 32'(rd_addr), 32'h23);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(8'h20 ^ key));
        chk("stall_bus", 32'(bus_req), 32'd1);
        rdy_mode = 0;
        wait_done(100);

        go(8'hFE, 8'd4);
        wait_done(50);

        r0 = done_rises;
        d0 = delivered;
        go(8'h00, 8'd0);
        wait_done(400);
        chk("len256", 32'(delivered - d0), 32'd256);
        chk("done_once", 32'(done_rises), 32'(r0 + 1));
        chk("bus_released", 32'(bus_req), 32'd0);

        d0 = delivered;
        go(8'h30, 8'd8);
        for (int k = 0; k < 100 && delivered - d0 < 2; k++) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        chk("ignored_start", 32'(delivered - d0), 32'd8);
        go(8'h50, 8'd3);
        @(negedge clk);
        chk("relaunch_done", 32'(done), 32'd0);
        wait_done(50);

        d0 = delivered;
        go(8'h60, 8'd16);
        for (int k = 0; k < 100 && delivered - d0 < 3; k++) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("abort");
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        go(8'h70, 8'd5);
        wait_done(50);

        chk("no_wr_full", 32'(wr_full), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
